// File: rtl/dest_match_scan.sv
// Scans a latched destination list one entry per clock for this node's ID or the broadcast ID.
// Reports the lowest-index hit; en low during a scan aborts back to idle with all outputs clear.
module dest_match_scan #(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    MAX_DEST   = 8,
  parameter int                    IDX_W      = 3,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = 16'hFFFF
) (
  input  logic                           clock,
  input  logic                           nrst,
  input  logic                           en,
  input  logic                           start,
  input  logic [WORD_WIDTH-1:0]          MY_NODE_ID,
  input  logic [IDX_W:0]                 dest_count,
  input  logic [MAX_DEST*WORD_WIDTH-1:0] dest_list,
  input  logic                           bcast_enable,
  output logic                           iamDestination,
  output logic                           isBroadcast,
  output logic [IDX_W-1:0]               match_index,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_DEST);

  state_t                                 state_q, state_d;
  logic [MAX_DEST-1:0][WORD_WIDTH-1:0]    list_q, list_d;
  logic [WORD_WIDTH-1:0]                  my_id_q, my_id_d;
  logic                                   bc_en_q, bc_en_d;
  logic [IDX_W:0]                         cnt_q, cnt_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic                                   iam_q, iam_d;
  logic                                   is_bc_q, is_bc_d;
  logic [IDX_W-1:0]                       match_idx_q, match_idx_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;

  logic [WORD_WIDTH-1:0] entry;
  logic [IDX_W:0]        idx_ext;
  logic                  uni_hit;
  logic                  bc_hit;

  // The entry read is only acted on while idx < cnt <= MAX_DEST, so it never leaves the list.
  assign entry   = list_q[idx_q];
  assign idx_ext = {1'b0, idx_q};
  assign uni_hit = (entry == my_id_q);
  assign bc_hit  = bc_en_q && (entry == BCAST_ID);

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    my_id_d     = my_id_q;
    bc_en_d     = bc_en_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    iam_d       = iam_q;
    is_bc_d     = is_bc_q;
    match_idx_d = match_idx_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d     = ST_ARMED;
          iam_d       = 1'b0;
          is_bc_d     = 1'b0;
          match_idx_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end
      end
      ST_ARMED: begin
        if (start) begin
          state_d = ST_SCAN;
          list_d  = dest_list;
          my_id_d = MY_NODE_ID;
          bc_en_d = bcast_enable;
          cnt_d   = (dest_count > MAX_CNT) ? MAX_CNT : dest_count;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          state_d     = ST_IDLE;
          iam_d       = 1'b0;
          is_bc_d     = 1'b0;
          match_idx_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end else if (idx_ext >= cnt_q) begin
          state_d     = ST_DONE;
          iam_d       = 1'b0;
          is_bc_d     = 1'b0;
          match_idx_d = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (uni_hit || bc_hit) begin
          // A unicast hit on the same entry outranks the broadcast interpretation.
          state_d     = ST_DONE;
          iam_d       = 1'b1;
          is_bc_d     = bc_hit && !uni_hit;
          match_idx_d = idx_q;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_ext + (IDX_W+1)'(1) == cnt_q) begin
            state_d     = ST_DONE;
            iam_d       = 1'b0;
            is_bc_d     = 1'b0;
            match_idx_d = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (en) begin
          state_d     = ST_ARMED;
          iam_d       = 1'b0;
          is_bc_d     = 1'b0;
          match_idx_d = '0;
          done_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        iam_d       = 1'b0;
        is_bc_d     = 1'b0;
        match_idx_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      list_q      <= '0;
      my_id_q     <= '0;
      bc_en_q     <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      iam_q       <= 1'b0;
      is_bc_q     <= 1'b0;
      match_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      my_id_q     <= my_id_d;
      bc_en_q     <= bc_en_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      iam_q       <= iam_d;
      is_bc_q     <= is_bc_d;
      match_idx_q <= match_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign iamDestination = iam_q;
  assign isBroadcast    = is_bc_q;
  assign match_index    = match_idx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_dest_match_scan.sv
// Directed table of scans plus hand sequences for abort, reset mid-scan, input changes and result hold.
module tb_dest_match_scan;

  logic         clock = 1'b0;
  logic         nrst;
  logic         en;
  logic         start;
  logic [15:0]  my_id;
  logic [3:0]   dest_count;
  logic [127:0] dest_list;
  logic         bcast_enable;
  logic         iam;
  logic         is_bc;
  logic [2:0]   match_index;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dest_match_scan #(
    .WORD_WIDTH(16), .MAX_DEST(8), .IDX_W(3), .BCAST_ID(16'hFFFF)
  ) dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .MY_NODE_ID(my_id), .dest_count(dest_count), .dest_list(dest_list),
    .bcast_enable(bcast_enable), .iamDestination(iam), .isBroadcast(is_bc),
    .match_index(match_index), .busy(busy), .done(done)
  );

  typedef struct {
    string        name;
    logic [15:0]  id;
    logic [3:0]   cnt;
    logic [127:0] lst;
    logic         bc;
    logic         e_iam;
    logic         e_bc;
    logic [2:0]   e_idx;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [127:0] mk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Starts with the block in IDLE or DONE, just after a falling edge; ends in DONE with en low.
  task automatic run_vec(input vec_t v);
    my_id = v.id; dest_count = v.cnt; dest_list = v.lst; bcast_enable = v.bc;
    en = 1'b1; start = 1'b0;
    tick();
    chk({v.name, "/arm_done"}, 32'(done), 0);
    chk({v.name, "/arm_iam"}, 32'(iam), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({v.name, "/busy"}, 32'(busy), 1);
    for (int c = 1; c <= v.lat; c++) begin
      tick();
      if (c < v.lat) begin
        chk({v.name, "/early_done"}, 32'(done), 0);
      end else begin
        chk({v.name, "/done"}, 32'(done), 1);
        chk({v.name, "/busy_end"}, 32'(busy), 0);
        chk({v.name, "/iam"}, 32'(iam), 32'(v.e_iam));
        chk({v.name, "/isbc"}, 32'(is_bc), 32'(v.e_bc));
        chk({v.name, "/idx"}, 32'(match_index), 32'(v.e_idx));
      end
    end
    en = 1'b0;
    tick();
    chk({v.name, "/hold_done"}, 32'(done), 1);
    chk({v.name, "/hold_iam"}, 32'(iam), 32'(v.e_iam));
    chk({v.name, "/hold_idx"}, 32'(match_index), 32'(v.e_idx));
  endtask

  initial begin
    vecs[0]  = '{"unicast", 16'h0012, 4'd4, mk(16'h3, 16'h7, 16'h12, 16'h20, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 3'd2, 3};
    vecs[1]  = '{"bcast", 16'h0009, 4'd2, mk(16'h5, 16'hFFFF, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b1, 3'd1, 2};
    vecs[2]  = '{"bcast_off", 16'h0009, 4'd2, mk(16'h5, 16'hFFFF, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 3'd0, 2};
    vecs[3]  = '{"count0", 16'h0004, 4'd0, mk(16'h4, 16'h4, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 3'd0, 1};
    vecs[4]  = '{"count15_miss", 16'h0099, 4'd15, mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, 1'b0, 1'b0, 3'd0, 8};
    vecs[5]  = '{"hit_idx7", 16'h0099, 4'd8, mk(1, 2, 3, 4, 5, 6, 7, 16'h99), 1'b1, 1'b1, 1'b0, 3'd7, 8};
    vecs[6]  = '{"priority", 16'h0002, 4'd3, mk(16'h2, 16'hFFFF, 16'h2, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0, 3'd0, 1};
    vecs[7]  = '{"bc_before_uni", 16'h0009, 4'd3, mk(16'h5, 16'hFFFF, 16'h9, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b1, 3'd1, 2};
    vecs[8]  = '{"myid_is_bcast", 16'hFFFF, 4'd2, mk(16'h1, 16'hFFFF, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0, 3'd1, 2};
    vecs[9]  = '{"clamp9_hit3", 16'h0044, 4'd9, mk(1, 2, 3, 16'h44, 5, 6, 7, 8), 1'b0, 1'b1, 1'b0, 3'd3, 4};
    vecs[10] = '{"beyond_count", 16'h0044, 4'd3, mk(1, 2, 3, 16'h44, 5, 6, 7, 8), 1'b0, 1'b0, 1'b0, 3'd0, 3};

    nrst = 1'b0; en = 1'b0; start = 1'b0; my_id = '0; dest_count = '0;
    dest_list = '0; bcast_enable = 1'b0;
    #12;
    chk("rst_iam", 32'(iam), 0);
    chk("rst_isbc", 32'(is_bc), 0);
    chk("rst_idx", 32'(match_index), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);

    // start while idle is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_start_busy", 32'(busy), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Inputs changed after the start edge must not disturb the running scan.
    my_id = 16'h0012; dest_count = 4'd4; bcast_enable = 1'b0;
    dest_list = mk(16'h3, 16'h7, 16'h12, 16'h20, 0, 0, 0, 0);
    en = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    my_id = 16'h0003; dest_list = '1; dest_count = 4'd0; bcast_enable = 1'b1;
    tick(); tick(); tick();
    chk("late_change_done", 32'(done), 1);
    chk("late_change_idx", 32'(match_index), 2);
    chk("late_change_isbc", 32'(is_bc), 0);
    en = 1'b0;
    tick();

    // Abort during a scan, then confirm done never rises.
    my_id = 16'h0099; dest_count = 4'd8; bcast_enable = 1'b0;
    dest_list = mk(1, 2, 3, 4, 5, 6, 7, 8);
    en = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_pre_busy", 32'(busy), 1);
    en = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    begin
      logic saw_done = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (done || busy) saw_done = 1'b1;
      end
      start = 1'b0;
      chk("abort_stays_idle", 32'(saw_done), 0);
    end

    // Fresh result after the abort.
    run_vec(vecs[0]);

    // Asynchronous reset in the middle of a scan.
    my_id = 16'h0099; dest_count = 4'd8; dest_list = mk(1, 2, 3, 4, 5, 6, 7, 8);
    en = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(posedge clock);
    #2;
    chk("pre_rst_busy", 32'(busy), 1);
    nrst = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_iam", 32'(iam), 0);
    @(negedge clock);
    nrst = 1'b1; en = 1'b0;
    @(negedge clock);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_match_scan.md
Name: dest_match_scan

Overview:
- Parametrised successor to the single-ID destination check.
- Latches a packet's destination list of up to MAX_DEST node IDs and scans it one entry per clock against MY_NODE_ID, with optional broadcast-ID recognition.
- Stops early on the first hit and reports whether this node is addressed, by unicast or broadcast, and at which list index.
- Sits in the node packet-handling path ahead of the forward/consume decision. Uses the same en/start/done handshake as the other node sub-blocks.

Parameters:
- WORD_WIDTH, 16, width of a node ID.
- MAX_DEST, 8, number of destination slots in the list (≥1).
- IDX_W, 3, index width; must satisfy 2^IDX_W ≥ MAX_DEST.
- BCAST_ID, 16'hFFFF, reserved broadcast node ID (WORD_WIDTH bits).

Ports:
- clock  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  arms the block from IDLE/DONE; low during SCAN aborts.
- start  in  1  launches a scan when ARMED.
- MY_NODE_ID  in  WORD_WIDTH  this node's ID; sampled at start.
- dest_count  in  IDX_W+1  number of valid list entries; sampled at start.
- dest_list  in  MAX_DEST*WORD_WIDTH  flattened list; entry i is bits [i*WORD_WIDTH +: WORD_WIDTH]; sampled at start.
- bcast_enable  in  1  when 1, BCAST_ID entries count as a match; sampled at start.
- iamDestination  out  1  node is addressed (unicast or broadcast).
- isBroadcast  out  1  the winning entry was BCAST_ID.
- match_index  out  IDX_W  index of the winning entry; 0 when no match.
- busy  out  1  high in SCAN.
- done  out  1  result valid.

Behaviour:
- Reset (nrst low, asynchronous): state=IDLE. iamDestination=0, isBroadcast=0, match_index=0, busy=0, done=0. All latched copies are cleared.
- States:
  - IDLE: en=1 → ARMED; outputs cleared at that edge.
  - ARMED: start=1 → SCAN. At the same edge, latch MY_NODE_ID, dest_list, bcast_enable, and cnt = min(dest_count, MAX_DEST). Set index=0 and busy=1. start=0 → stay in ARMED.
  - SCAN: one entry per edge at the current index.
    - cnt==0, or index ≥ cnt: → DONE with no match.
    - Unicast match (entry == MY_NODE_ID), or broadcast match (bcast_enable && entry == BCAST_ID): → DONE. Set iamDestination=1 and match_index=index. Set isBroadcast=1 only for a broadcast match that is not also a unicast match.
    - Otherwise: index += 1. If index was cnt−1, → DONE with no match.
  - DONE: done=1 and busy=0. Results are held stable. en=1 → ARMED; done, iamDestination, isBroadcast and match_index clear at that edge. en=0 → stay in DONE.
- Latency: start sampled at edge T0, first hit at index k → done=1 after edge T0+k+1. No hit → done after edge T0+max(cnt,1).
- Priority: the lowest-index hit wins. A MY_NODE_ID equal to BCAST_ID counts as a unicast match (isBroadcast=0).
- en=0 while in SCAN: abort to IDLE at that edge. All outputs are 0; done is never asserted.
- start outside ARMED is ignored. Input changes after the start edge do not affect the running scan.
- dest_count > MAX_DEST is clamped to MAX_DEST; it never wraps and never reads beyond the list.
- Undefined state encodings return to IDLE.

Test Plan:
- Reset mid-scan: assert nrst=0 asynchronously during SCAN → all outputs 0 immediately, without waiting for a clock edge; state=IDLE.
- Unicast hit: MY_NODE_ID=0x0012, count=4, list={0x0003,0x0007,0x0012,0x0020}. Arm, start at T0 → after edge T0+3: done=1, iamDestination=1, isBroadcast=0, match_index=2, busy=0.
- Broadcast hit: bcast_enable=1, list={0x0005,0xFFFF}, count=2, MY_NODE_ID=0x0009 → done after T0+2, iamDestination=1, isBroadcast=1, match_index=1. Rerun with bcast_enable=0 → iamDestination=0 after T0+2.
- Edge counts: count=0 → done after T0+1, no match. count=15 with MAX_DEST=8 and no hit → done after T0+8, match_index=0. Full-depth hit only at index 7 → match_index=7 after T0+8.
- Abort and re-arm: drop en during SCAN → IDLE, done stays 0. From DONE, en=1 → outputs clear next edge and the block is ARMED; a second start gives a fresh correct result.
- Priority: list={0x0002,0xFFFF,0x0002}, MY_NODE_ID=0x0002, bcast_enable=1 → match_index=0, isBroadcast=0.
